// File: rtl/dff.sv
// ============================================================================
//  Module      : dff
//  Description : WIDTH-bit edge-triggered D register with async reset,
//                sync clear, load enable and toggle. Optional inverted output
//                QN is enabled by defining DFF_QN_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dff #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             tgl,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
`ifdef DFF_QN_EN
    ,
    output logic [WIDTH-1:0] QN
`endif
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Priority: clear, then load, then toggle, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = RST_VAL;
        end else if (en) begin
            q_d = D;
        end else if (tgl) begin
            q_d = ~q_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

`ifdef DFF_QN_EN
    assign QN = ~q_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dff.sv
// Self-checking bench for dff: 4-bit cell against a next-value model, a 1-bit
// toggle cell and a three-stage ripple divider.
`default_nettype none

module tb_dff;

    localparam logic [3:0] c_RV  = 4'hA;
    localparam int         c_PER = 10;

    logic       clk;
    logic       rst, en, clr, tgl;
    logic [3:0] D, Q;
    logic       t_rst, t_tgl, t_q;
    logic       t_zero;
    logic       div_rst, dq0, dq1, dq2;
    logic       dd0, dd1, dd2;
    logic       one;
`ifdef DFF_QN_EN
    logic [3:0] QN;
    logic       t_qn, dqn0, dqn1, dqn2;
`endif

    int         n_chk;
    int         n_fail;
    logic [3:0] exp_now;
    logic [3:0] pend;
    logic       chk_en;
    logic       t_done, d_done;
    longint     rise_t[$];

    assign t_zero = 1'b0;
    assign one    = 1'b1;
    assign dd0    = ~dq0;
    assign dd1    = ~dq1;
    assign dd2    = ~dq2;

    dff #(.WIDTH(4), .RST_VAL(c_RV)) u_dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .tgl(tgl), .D(D), .Q(Q)
`ifdef DFF_QN_EN
        , .QN(QN)
`endif
    );

    dff #(.WIDTH(1)) u_tgl (
        .clk(clk), .rst(t_rst), .en(t_zero), .clr(t_zero), .tgl(t_tgl),
        .D(t_zero), .Q(t_q)
`ifdef DFF_QN_EN
        , .QN(t_qn)
`endif
    );

    dff #(.WIDTH(1)) u_div0 (
        .clk(clk), .rst(div_rst), .en(one), .clr(t_zero), .tgl(t_zero),
        .D(dd0), .Q(dq0)
`ifdef DFF_QN_EN
        , .QN(dqn0)
`endif
    );

    dff #(.WIDTH(1)) u_div1 (
        .clk(dq0), .rst(div_rst), .en(one), .clr(t_zero), .tgl(t_zero),
        .D(dd1), .Q(dq1)
`ifdef DFF_QN_EN
        , .QN(dqn1)
`endif
    );

    dff #(.WIDTH(1)) u_div2 (
        .clk(dq1), .rst(div_rst), .en(one), .clr(t_zero), .tgl(t_zero),
        .D(dd2), .Q(dq2)
`ifdef DFF_QN_EN
        , .QN(dqn2)
`endif
    );

    initial clk = 1'b0;
    always #(c_PER / 2) clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Value Q must take after an edge, straight from the priority list.
    function automatic logic [3:0] rule(input logic [3:0] cur, input logic e,
                                        input logic c, input logic t, input logic [3:0] d);
        if (c) return c_RV;
        if (e) return d;
        if (t) return ~cur;
        return cur;
    endfunction

    task automatic drv(input logic e, input logic c, input logic t, input logic [3:0] d);
        en   = e;
        clr  = c;
        tgl  = t;
        D    = d;
        pend = rule(exp_now, e, c, t, d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        exp_now = rst ? c_RV : pend;
    endtask

    // Per-cycle comparison of the 4-bit cell against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] inv;
            check("q_model", Q, exp_now);
`ifdef DFF_QN_EN
            inv = ~Q;
            check("qn_inv", QN, inv);
`else
            inv = '0;
`endif
        end
    end

    // Toggle cell: 0 out of reset, then 1,0,1,0.
    initial begin
        logic [3:0] seq [4];
        seq    = '{4'd1, 4'd0, 4'd1, 4'd0};
        t_done = 1'b0;
        t_rst  = 1'b1;
        t_tgl  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        t_rst = 1'b0;
        t_tgl = 1'b1;
        check("tgl_rst", {3'b0, t_q}, 4'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("tgl_seq", {3'b0, t_q}, seq[k]);
        end
        t_done = 1'b1;
    end

    always @(posedge dq2) begin
        if (!div_rst) rise_t.push_back($time);
    end

    // Ripple divider: stage k toggles once per rising edge of stage k-1.
    initial begin
        int c1, c2;
        d_done  = 1'b0;
        div_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        div_rst = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            #1;
            c1 = (n + 1) / 2;
            c2 = (c1 + 1) / 2;
            check("div_s0", {3'b0, dq0}, 4'(n % 2));
            check("div_s1", {3'b0, dq1}, 4'(c1 % 2));
            check("div_s2", {3'b0, dq2}, 4'(c2 % 2));
        end
        check_int("div_rises", rise_t.size(), 2);
        if (rise_t.size() >= 2)
            check_int("div_period", int'(rise_t[1] - rise_t[0]), 8 * c_PER);
        d_done = 1'b1;
    end

    initial begin
        logic [3:0] qn_rv;
        int         r;
        n_chk   = 0;
        n_fail  = 0;
        chk_en  = 1'b0;
        rst     = 1'b1;
        en      = 1'b0;
        clr     = 1'b0;
        tgl     = 1'b0;
        D       = 4'h0;
        exp_now = c_RV;
        pend    = c_RV;
        qn_rv   = ~c_RV;
        #2;
        check("reset_q", Q, c_RV);
`ifdef DFF_QN_EN
        check("qn_in_rst", QN, qn_rv);
`endif
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        drv(1'b1, 1'b0, 1'b0, 4'h3);
        step();
        check("load3", Q, 4'h3);

        // Async reset between edges.
        #1;
        rst = 1'b1;
        #1;
        check("async_rst", Q, c_RV);
`ifdef DFF_QN_EN
        check("qn_async_rst", QN, qn_rv);
`endif
        rst     = 1'b0;
        exp_now = c_RV;

        drv(1'b1, 1'b0, 1'b0, 4'h5);
        step();
        check("load5", Q, 4'h5);
        drv(1'b0, 1'b0, 1'b0, 4'hF);
        step();
        check("hold5", Q, 4'h5);
        drv(1'b1, 1'b1, 1'b0, 4'h7);
        step();
        check("clr_over_en", Q, c_RV);
        drv(1'b1, 1'b0, 1'b1, 4'h1);
        step();
        check("en_over_tgl", Q, 4'h1);
        drv(1'b0, 1'b0, 1'b1, 4'h9);
        step();
        check("tgl4", Q, 4'hE);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 39);
            if (r == 0) begin
                #1;
                rst = 1'b1;
                #1;
                rst     = 1'b0;
                exp_now = c_RV;
            end else if (r == 1) begin
                rst     = 1'b1;
                exp_now = c_RV;
                step();
                rst = 1'b0;
            end
            drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            step();
        end
        chk_en = 1'b0;

        for (int w = 0; w < 200 && !(t_done && d_done); w++) @(posedge clk);
        check_int("bench_done", int'({t_done, d_done}), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
